// File: rtl/rx_pause_ctrl.sv
// Receive-side 802.3x PAUSE snooper: parses the RX MAC stream header, accepts good
// PAUSE frames and runs a link-speed-scaled quanta timer that drives rx_pause.
module rx_pause_ctrl #(
    parameter logic [47:0] LOCAL_MAC           = 48'h02_00_00_00_00_01,
    parameter int          QUANTUM_CYCLES_GMII = 64,
    parameter int          QUANTUM_CYCLES_MII  = 128,
    parameter int          SYNC_IDLE_CYCLES    = 8
) (
    input  logic        rgmii_mac_rx_clk,
    input  logic        reset_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        s_axis_trdy,
    input  logic        mii_sel,
    input  logic        pause_en,
    output logic        rx_pause,
    output logic        pause_frame_pulse,
    output logic [15:0] pause_quanta,
    output logic [15:0] pause_remaining,
    output logic [15:0] pause_frame_cnt
);

    localparam logic [47:0] PAUSE_MCAST = 48'h01_80_C2_00_00_01;
    localparam int          IW          = $clog2(SYNC_IDLE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(SYNC_IDLE_CYCLES - 1);
    localparam logic [15:0] LIM_GMII    = 16'(QUANTUM_CYCLES_GMII - 1);
    localparam logic [15:0] LIM_MII     = 16'(QUANTUM_CYCLES_MII - 1);

    typedef enum logic [1:0] {SYNC, IDLE, HDR, SKIP} state_t;

    state_t        state, state_nxt;
    logic          beat;
    logic          frame_end;
    logic [4:0]    byte_cnt;
    logic [IW-1:0] idle_cnt;
    logic [143:0]  hdr;
    logic [47:0]   da_v;
    logic [15:0]   etype_v;
    logic [15:0]   opcode_v;
    logic [15:0]   pause_time;
    logic          accept;
    logic [15:0]   timer, timer_nxt;
    logic [15:0]   presc, presc_nxt;
    logic [15:0]   lim_m1;

    assign beat = s_axis_tvalid & s_axis_trdy;

    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        case (state)
            SYNC: begin
                if (beat && s_axis_tlast)
                    state_nxt = IDLE;
                else if (!s_axis_tvalid && idle_cnt == IDLE_LAST)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (beat && !s_axis_tlast)
                    state_nxt = HDR;
            end
            HDR: begin
                if (beat) begin
                    if (s_axis_tlast) begin
                        // Anything shorter than 18 bytes is a runt and is dropped.
                        state_nxt = IDLE;
                        frame_end = (byte_cnt == 5'd17);
                    end else if (byte_cnt == 5'd17) begin
                        state_nxt = SKIP;
                    end
                end
            end
            SKIP: begin
                if (beat && s_axis_tlast) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge rgmii_mac_rx_clk) begin
        if (!reset_n) begin
            state    <= SYNC;
            idle_cnt <= '0;
            byte_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (s_axis_tvalid)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_LAST)
                idle_cnt <= idle_cnt + 1'b1;
            if (beat) begin
                if (state == IDLE)
                    byte_cnt <= 5'd1;
                else if ((state == HDR || state == SKIP) && byte_cnt != 5'd18)
                    byte_cnt <= byte_cnt + 5'd1;
            end
        end
    end

    // Header bytes enter at the bottom; after 18 beats byte 0 sits in [143:136].
    always_ff @(posedge rgmii_mac_rx_clk) begin
        if (beat && (state == IDLE || state == HDR))
            hdr <= {hdr[135:0], s_axis_tdata};
    end

    // When byte 17 is itself the tlast beat it has not been shifted in yet.
    always_comb begin
        if (state == HDR) begin
            da_v       = hdr[135:88];
            etype_v    = hdr[39:24];
            opcode_v   = hdr[23:8];
            pause_time = {hdr[7:0], s_axis_tdata};
        end else begin
            da_v       = hdr[143:96];
            etype_v    = hdr[47:32];
            opcode_v   = hdr[31:16];
            pause_time = hdr[15:0];
        end
    end

    assign accept = frame_end && !s_axis_tuser && pause_en &&
                    (da_v == PAUSE_MCAST || da_v == LOCAL_MAC) &&
                    etype_v == 16'h8808 && opcode_v == 16'h0001;

    assign lim_m1 = mii_sel ? LIM_MII : LIM_GMII;

    always_comb begin
        timer_nxt = timer;
        presc_nxt = presc;
        if (!pause_en) begin
            timer_nxt = '0;
            presc_nxt = '0;
        end else if (accept) begin
            timer_nxt = pause_time;
            presc_nxt = '0;
        end else if (timer != 16'd0) begin
            // >= so a speed change that shrinks the quantum wraps at once.
            if (presc >= lim_m1) begin
                presc_nxt = '0;
                timer_nxt = timer - 16'd1;
            end else begin
                presc_nxt = presc + 16'd1;
            end
        end
    end

    always_ff @(posedge rgmii_mac_rx_clk) begin
        if (!reset_n) begin
            timer             <= '0;
            presc             <= '0;
            rx_pause          <= 1'b0;
            pause_frame_pulse <= 1'b0;
            pause_quanta      <= '0;
            pause_frame_cnt   <= '0;
        end else begin
            timer             <= timer_nxt;
            presc             <= presc_nxt;
            rx_pause          <= (timer_nxt != 16'd0);
            pause_frame_pulse <= accept;
            pause_frame_cnt   <= pause_frame_cnt + {15'd0, accept};
            if (accept)
                pause_quanta <= pause_time;
        end
    end

    assign pause_remaining = timer;

endmodule

// File: tb/tb_rx_pause_ctrl.sv
// Directed bench for rx_pause_ctrl: PAUSE acceptance, rejection, timer, reload,
// enable gating and reset recovery.
module tb_rx_pause_ctrl;

    localparam logic [47:0] MCAST = 48'h01_80_C2_00_00_01;
    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  tdata = 8'h00;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tuser = 1'b0;
    logic        trdy = 1'b1;
    logic        mii_sel = 1'b0;
    logic        pause_en = 1'b1;
    logic        rx_pause;
    logic        pause_frame_pulse;
    logic [15:0] pause_quanta;
    logic [15:0] pause_remaining;
    logic [15:0] pause_frame_cnt;

    int errors = 0;
    int checks = 0;

    rx_pause_ctrl dut (
        .rgmii_mac_rx_clk  (clk),
        .reset_n           (reset_n),
        .s_axis_tdata      (tdata),
        .s_axis_tvalid     (tvalid),
        .s_axis_tlast      (tlast),
        .s_axis_tuser      (tuser),
        .s_axis_trdy       (trdy),
        .mii_sel           (mii_sel),
        .pause_en          (pause_en),
        .rx_pause          (rx_pause),
        .pause_frame_pulse (pause_frame_pulse),
        .pause_quanta      (pause_quanta),
        .pause_remaining   (pause_remaining),
        .pause_frame_cnt   (pause_frame_cnt)
    );

    always #4 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns #1 after the edge that consumed the tlast beat (cycle N+1).
    task automatic send_frame(input logic [47:0] da, input logic [15:0] et,
                              input logic [15:0] op, input logic [15:0] pt,
                              input int len, input logic err, input logic half,
                              input int rst_lo, input int rst_hi);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            if (i == rst_lo) reset_n = 1'b0;
            if (i == rst_hi) reset_n = 1'b1;
            if (half) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                step(1);
            end
            if (i < 6)       b = da[47-8*i -: 8];
            else if (i < 12) b = 8'h10 + 8'(i);
            else if (i == 12) b = et[15:8];
            else if (i == 13) b = et[7:0];
            else if (i == 14) b = op[15:8];
            else if (i == 15) b = op[7:0];
            else if (i == 16) b = pt[15:8];
            else if (i == 17) b = pt[7:0];
            else             b = 8'h00;
            tdata  = b;
            tvalid = 1'b1;
            tlast  = (i == len - 1);
            tuser  = (i == len - 1) ? err : 1'b0;
            step(1);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    // Counts cycles with rx_pause high, starting at the current cycle.
    task automatic measure(output int n);
        n = 0;
        while (rx_pause && n < 20000) begin
            n++;
            step(1);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(1);
        checks++; if (rx_pause !== 1'b0) begin errors++; $display("FAIL reset_rx_pause got=%0b exp=0", rx_pause); end
        checks++; if (pause_frame_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%0b exp=0", pause_frame_pulse); end
        checks++; if (pause_quanta !== 16'h0) begin errors++; $display("FAIL reset_quanta got=%h exp=0000", pause_quanta); end
        checks++; if (pause_remaining !== 16'h0) begin errors++; $display("FAIL reset_remaining got=%h exp=0000", pause_remaining); end
        checks++; if (pause_frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0000", pause_frame_cnt); end
        step(10);
    endtask

    task automatic test_gmii;
        int n;
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0003, 60, 1'b0, 1'b0, -1, -1);
        checks++; if (pause_frame_pulse !== 1'b1) begin errors++; $display("FAIL gmii_pulse got=%0b exp=1", pause_frame_pulse); end
        checks++; if (pause_frame_cnt !== 16'd1) begin errors++; $display("FAIL gmii_cnt got=%0d exp=1", pause_frame_cnt); end
        checks++; if (pause_quanta !== 16'd3) begin errors++; $display("FAIL gmii_quanta got=%0d exp=3", pause_quanta); end
        checks++; if (pause_remaining !== 16'd3) begin errors++; $display("FAIL gmii_remaining got=%0d exp=3", pause_remaining); end
        measure(n);
        checks++; if (n !== 192) begin errors++; $display("FAIL gmii_duration got=%0d exp=192", n); end
        checks++; if (pause_frame_pulse !== 1'b0) begin errors++; $display("FAIL gmii_pulse_end got=%0b exp=0", pause_frame_pulse); end
        step(5);
    endtask

    task automatic test_mii;
        int n;
        mii_sel = 1'b1;
        step(2);
        send_frame(LMAC, 16'h8808, 16'h0001, 16'h0002, 60, 1'b0, 1'b1, -1, -1);
        checks++; if (pause_frame_pulse !== 1'b1) begin errors++; $display("FAIL mii_pulse got=%0b exp=1", pause_frame_pulse); end
        checks++; if (pause_frame_cnt !== 16'd2) begin errors++; $display("FAIL mii_cnt got=%0d exp=2", pause_frame_cnt); end
        measure(n);
        checks++; if (n !== 256) begin errors++; $display("FAIL mii_duration got=%0d exp=256", n); end
        mii_sel = 1'b0;
        step(5);
    endtask

    task automatic test_reject;
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0004, 60, 1'b1, 1'b0, -1, -1);
        checks++; if (rx_pause !== 1'b0 || pause_frame_pulse !== 1'b0) begin errors++; $display("FAIL rej_tuser got=%0b/%0b exp=0/0", rx_pause, pause_frame_pulse); end
        step(2);
        send_frame(MCAST, 16'h0800, 16'h0001, 16'h0004, 60, 1'b0, 1'b0, -1, -1);
        checks++; if (rx_pause !== 1'b0 || pause_frame_pulse !== 1'b0) begin errors++; $display("FAIL rej_etype got=%0b/%0b exp=0/0", rx_pause, pause_frame_pulse); end
        step(2);
        send_frame(MCAST, 16'h8808, 16'h0002, 16'h0004, 60, 1'b0, 1'b0, -1, -1);
        checks++; if (rx_pause !== 1'b0 || pause_frame_pulse !== 1'b0) begin errors++; $display("FAIL rej_opcode got=%0b/%0b exp=0/0", rx_pause, pause_frame_pulse); end
        step(2);
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0004, 16, 1'b0, 1'b0, -1, -1);
        checks++; if (rx_pause !== 1'b0 || pause_frame_pulse !== 1'b0) begin errors++; $display("FAIL rej_runt got=%0b/%0b exp=0/0", rx_pause, pause_frame_pulse); end
        checks++; if (pause_frame_cnt !== 16'd2) begin errors++; $display("FAIL rej_cnt got=%0d exp=2", pause_frame_cnt); end
        step(5);
    endtask

    task automatic test_reload;
        int n;
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0100, 60, 1'b0, 1'b0, -1, -1);
        checks++; if (pause_remaining !== 16'h0100) begin errors++; $display("FAIL reload_first got=%h exp=0100", pause_remaining); end
        n = 0;
        while (pause_remaining != 16'h0080 && n < 20000) begin
            n++;
            step(1);
        end
        checks++; if (pause_remaining !== 16'h0080) begin errors++; $display("FAIL reload_wait got=%h exp=0080", pause_remaining); end
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0000, 60, 1'b0, 1'b0, -1, -1);
        checks++; if (rx_pause !== 1'b0) begin errors++; $display("FAIL reload_zero_pause got=%0b exp=0", rx_pause); end
        checks++; if (pause_remaining !== 16'h0) begin errors++; $display("FAIL reload_zero_rem got=%h exp=0000", pause_remaining); end
        checks++; if (pause_quanta !== 16'h0 || pause_frame_pulse !== 1'b1) begin errors++; $display("FAIL reload_zero_q got=%h/%0b exp=0000/1", pause_quanta, pause_frame_pulse); end
        step(2);
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0100, 60, 1'b0, 1'b0, -1, -1);
        step(2);
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0005, 60, 1'b0, 1'b0, -1, -1);
        checks++; if (pause_remaining !== 16'd5) begin errors++; $display("FAIL reload_five got=%0d exp=5", pause_remaining); end
        checks++; if (pause_quanta !== 16'd5 || rx_pause !== 1'b1) begin errors++; $display("FAIL reload_five_q got=%0d/%0b exp=5/1", pause_quanta, rx_pause); end
        checks++; if (pause_frame_cnt !== 16'd6) begin errors++; $display("FAIL reload_cnt got=%0d exp=6", pause_frame_cnt); end
        measure(n);
        checks++; if (n !== 320) begin errors++; $display("FAIL reload_duration got=%0d exp=320", n); end
        step(5);
    endtask

    task automatic test_pause_en;
        int n;
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0020, 60, 1'b0, 1'b0, -1, -1);
        n = 0;
        while (pause_remaining != 16'd10 && n < 5000) begin
            n++;
            step(1);
        end
        checks++; if (pause_remaining !== 16'd10 || rx_pause !== 1'b1) begin errors++; $display("FAIL en_wait got=%0d/%0b exp=10/1", pause_remaining, rx_pause); end
        pause_en = 1'b0;
        step(1);
        checks++; if (rx_pause !== 1'b0) begin errors++; $display("FAIL en_drop_pause got=%0b exp=0", rx_pause); end
        checks++; if (pause_remaining !== 16'd0) begin errors++; $display("FAIL en_drop_rem got=%0d exp=0", pause_remaining); end
        step(3);
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0007, 60, 1'b0, 1'b0, -1, -1);
        checks++; if (rx_pause !== 1'b0 || pause_frame_pulse !== 1'b0) begin errors++; $display("FAIL en_ignored got=%0b/%0b exp=0/0", rx_pause, pause_frame_pulse); end
        checks++; if (pause_frame_cnt !== 16'd7) begin errors++; $display("FAIL en_cnt got=%0d exp=7", pause_frame_cnt); end
        pause_en = 1'b1;
        step(5);
    endtask

    task automatic test_reset_midframe;
        int n;
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0009, 60, 1'b0, 1'b0, 4, 8);
        checks++; if (rx_pause !== 1'b0 || pause_frame_pulse !== 1'b0) begin errors++; $display("FAIL rst_frame_ignored got=%0b/%0b exp=0/0", rx_pause, pause_frame_pulse); end
        checks++; if (pause_frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", pause_frame_cnt); end
        step(10);
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0001, 60, 1'b0, 1'b0, -1, -1);
        checks++; if (rx_pause !== 1'b1 || pause_frame_cnt !== 16'd1) begin errors++; $display("FAIL rst_next_frame got=%0b/%0d exp=1/1", rx_pause, pause_frame_cnt); end
        measure(n);
        checks++; if (n !== 64) begin errors++; $display("FAIL rst_next_duration got=%0d exp=64", n); end
        step(3);
    endtask

    task automatic test_cnt_wrap;
        force dut.pause_frame_cnt = 16'hFFFF;
        step(2);
        release dut.pause_frame_cnt;
        step(2);
        checks++; if (pause_frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=ffff", pause_frame_cnt); end
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0002, 60, 1'b0, 1'b0, -1, -1);
        checks++; if (pause_frame_cnt !== 16'h0000 || pause_frame_pulse !== 1'b1) begin errors++; $display("FAIL wrap_cnt got=%h/%0b exp=0000/1", pause_frame_cnt, pause_frame_pulse); end
        step(5);
    endtask

    initial begin
        test_reset;
        test_gmii;
        test_mii;
        test_reject;
        test_reload;
        test_pause_en;
        test_reset_midframe;
        test_cnt_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
